// File: rtl/mem_stall_ctrl.sv
// MEM-stage access sequencer: freezes the pipeline while a load/store runs a req/ack
// handshake with data memory. Define MEM_STALL_PERF_EN to add the perf_stall_o stall-cycle counter.
module mem_stall_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] Addr_i,
    input  logic [31:0] WrData_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o,
    output logic        bubble_o,
    output logic [31:0] RdData_o,
    output logic        err_o
`ifdef MEM_STALL_PERF_EN
    ,
    output logic [31:0] perf_stall_o
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [31:0]      ERR_DATA  = 32'hDEAD_BEEF;

    state_t           stateReg;
    logic [CNT_W-1:0] cntReg;
    logic             accReq;

    assign accReq = MemRead_i | MemWrite_i;

    // The access is flagged in the same cycle it is detected so EX/MEM never advances past it.
    assign stall_o  = ((stateReg == IDLE) && accReq) || (stateReg == REQ);
    assign bubble_o = stall_o;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stateReg    <= IDLE;
            cntReg      <= '0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            RdData_o    <= '0;
            err_o       <= 1'b0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (accReq) begin
                        stateReg    <= REQ;
                        cntReg      <= '0;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= MemWrite_i;
                        mem_addr_o  <= Addr_i;
                        mem_wdata_o <= WrData_i;
                    end
                end
                REQ: begin
                    if (mem_ack_i) begin
                        if (!mem_we_o) begin
                            RdData_o <= mem_rdata_i;
                        end
                        mem_req_o <= 1'b0;
                        stateReg  <= DONE;
                    end else if (cntReg == CNT_LAST) begin
                        // Abort: hand the pipeline a poison value and let it continue.
                        err_o     <= 1'b1;
                        RdData_o  <= ERR_DATA;
                        mem_req_o <= 1'b0;
                        stateReg  <= DONE;
                    end else begin
                        cntReg <= cntReg + 1'b1;
                    end
                end
                DONE: begin
                    stateReg <= IDLE;
                end
                default: begin
                    stateReg  <= IDLE;
                    mem_req_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_STALL_PERF_EN
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            perf_stall_o <= '0;
        end else if (stall_o && (perf_stall_o != 32'hFFFF_FFFF)) begin
            perf_stall_o <= perf_stall_o + 32'd1;
        end
    end
`endif

endmodule
